digit_fetch_sched: RTL and testbench

- Per-line scheduler that time-shares the single digit-glyph lookup unit (number -> digit_index ROM, registered) among the clock's display slots.
- At each character line start it walks every slot, issues one lookup per cycle, and caches the returned digit_index per slot.
- During active video it serves the cached index for the slot under the beam.
- Sits between the BCD time counters and the pixel/column renderer.

---
 rtl/digit_pkg.sv | 25 ++
 rtl/digit_tag_pipe.sv | 44 ++++
 rtl/digit_fetch_sched.sv | 186 ++++++++++++++++++
 tb/tb_digit_fetch_sched.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_pkg.sv
// Shared types and constants for the digit fetch scheduler.
package digit_pkg;

  localparam int unsigned NSLOT_BASE  = 6;
  localparam int unsigned NSLOT_COLON = 8;

  localparam logic [3:0] BLANK_CODE_DEF = 4'd10;
  localparam logic [3:0] COLON_CODE_DEF = 4'd11;

  typedef logic [2:0] slot_t;
  typedef logic [3:0] code_t;
  typedef logic [5:0] glyph_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  // Replace a non-decimal BCD nibble with the blank glyph code.
  function automatic code_t bcd_sanitize(input code_t nib, input code_t blank);
    return (nib > 4'd9) ? blank : nib;
  endfunction

endpackage

// File: rtl/digit_tag_pipe.sv
// Delay line carrying valid+slot tag alongside the registered lookup unit.
// A synchronous flush drops every in-flight tag.
module digit_tag_pipe
  import digit_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_flush,
  input  logic  i_valid,
  input  slot_t i_tag,
  output logic  o_valid,
  output slot_t o_tag
);

  logic  r_valid [DEPTH];
  slot_t r_tag   [DEPTH];

  // Shift valid/tag one stage per cycle; flush wins over the incoming entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
      end
    end else if (i_flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_tag[0]   <= i_tag;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_tag[i]   <= r_tag[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_tag   = r_tag[DEPTH-1];

endmodule

// File: rtl/digit_fetch_sched.sv
// Per-line scheduler sharing one registered digit-glyph lookup unit among
// the clock display slots; caches one glyph index per slot for the renderer.
// Optional colon slots: define DIGIT_SCHED_COLON_EN (8 slots instead of 6).
module digit_fetch_sched
  import digit_pkg::*;
#(
  parameter int unsigned LK_LATENCY = 1,
  parameter code_t       BLANK_CODE = BLANK_CODE_DEF,
  parameter code_t       COLON_CODE = COLON_CODE_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic [23:0] time_bcd,
  output logic [3:0]  lk_number,
  output logic        lk_valid,
  input  logic [5:0]  lk_digit_index,
  input  logic [2:0]  slot_sel,
  input  logic        slot_valid,
  output logic [5:0]  digit_index,
  output logic        digit_valid,
  output logic        busy
);

`ifdef DIGIT_SCHED_COLON_EN
  localparam int unsigned NSLOT = NSLOT_COLON;
`else
  localparam int unsigned NSLOT = NSLOT_BASE;
`endif
  localparam slot_t      LAST_SLOT  = slot_t'(NSLOT - 1);
  localparam logic [1:0] LAST_DRAIN = 2'(LK_LATENCY - 1);

  state_t           r_state;
  slot_t            r_slot;
  logic [1:0]       r_drain;
  logic [23:0]      r_snap;
  glyph_idx_t       r_cache [NSLOT];
  logic [NSLOT-1:0] r_cache_valid;
  glyph_idx_t       r_digit_index;
  logic             r_digit_valid;

  state_t     w_state_nx;
  slot_t      w_slot_nx;
  logic [1:0] w_drain_nx;
  logic       w_lk_valid;
  code_t      w_lk_number;
  logic       w_abort;
  logic       w_tag_valid;
  slot_t      w_tag;
  logic       w_sel_in_range;

  // Lookup code for a slot, taken from the sanitised snapshot.
  function automatic code_t slot_code(input slot_t s, input logic [23:0] snap);
    code_t c;
`ifdef DIGIT_SCHED_COLON_EN
    case (s)
      3'd0:        c = snap[23:20];
      3'd1:        c = snap[19:16];
      3'd2, 3'd5:  c = COLON_CODE;
      3'd3:        c = snap[15:12];
      3'd4:        c = snap[11:8];
      3'd6:        c = snap[7:4];
      default:     c = snap[3:0];
    endcase
`else
    case (s)
      3'd0:    c = snap[23:20];
      3'd1:    c = snap[19:16];
      3'd2:    c = snap[15:12];
      3'd3:    c = snap[11:8];
      3'd4:    c = snap[7:4];
      default: c = snap[3:0];
    endcase
`endif
    return c;
  endfunction

  assign w_abort        = line_start && (r_state != IDLE);
  assign w_sel_in_range = ({1'b0, slot_sel} < 4'(NSLOT));

  // Time snapshot; invalid BCD nibbles are stored as the blank code.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_snap <= '0;
    end else if (frame_start) begin
      for (int unsigned i = 0; i < 6; i++) begin
        r_snap[i*4 +: 4] <= bcd_sanitize(time_bcd[i*4 +: 4], BLANK_CODE);
      end
    end
  end

  // FSM state, slot cursor and drain counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_slot  <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_state_nx;
      r_slot  <= w_slot_nx;
      r_drain <= w_drain_nx;
    end
  end

  // Next-state and lookup request; line_start (re)starts at slot 0 from any state.
  always_comb begin
    w_state_nx  = r_state;
    w_slot_nx   = r_slot;
    w_drain_nx  = r_drain;
    w_lk_valid  = 1'b0;
    w_lk_number = '0;
    case (r_state)
      FETCH: begin
        w_lk_valid  = 1'b1;
        w_lk_number = slot_code(r_slot, r_snap);
        if (r_slot == LAST_SLOT) begin
          w_state_nx = DRAIN;
          w_drain_nx = '0;
        end else begin
          w_slot_nx = r_slot + slot_t'(1);
        end
      end
      DRAIN: begin
        if (r_drain == LAST_DRAIN) begin
          w_state_nx = IDLE;
        end else begin
          w_drain_nx = r_drain + 2'd1;
        end
      end
      default: ;
    endcase
    if (line_start) begin
      w_state_nx = FETCH;
      w_slot_nx  = '0;
      w_drain_nx = '0;
    end
  end

  digit_tag_pipe #(
    .DEPTH (LK_LATENCY)
  ) u_tag_pipe (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_flush (w_abort),
    .i_valid (w_lk_valid),
    .i_tag   (r_slot),
    .o_valid (w_tag_valid),
    .o_tag   (w_tag)
  );

  // Cache capture as tags leave the pipe; an abort invalidates every slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NSLOT; i++) begin
        r_cache[i] <= '0;
      end
      r_cache_valid <= '0;
    end else if (w_abort) begin
      r_cache_valid <= '0;
    end else if (w_tag_valid) begin
      r_cache[w_tag]       <= lk_digit_index;
      r_cache_valid[w_tag] <= 1'b1;
    end
  end

  // Registered read port; out-of-range slots read invalid and hold the index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_digit_index <= '0;
      r_digit_valid <= 1'b0;
    end else if (w_sel_in_range) begin
      r_digit_index <= r_cache[slot_sel];
      r_digit_valid <= slot_valid && r_cache_valid[slot_sel];
    end else begin
      r_digit_valid <= 1'b0;
    end
  end

  assign lk_number   = w_lk_number;
  assign lk_valid    = w_lk_valid;
  assign digit_index = r_digit_index;
  assign digit_valid = r_digit_valid;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_digit_fetch_sched.sv
// Directed testbench for digit_fetch_sched with a registered ROM model
// returning number*5 after LK_LATENCY cycles.
// Honours DIGIT_SCHED_COLON_EN (8 slots, LK_LATENCY=2).
module tb_digit_fetch_sched;

`ifdef DIGIT_SCHED_COLON_EN
  localparam int LAT   = 2;
  localparam int NSLOT = 8;
`else
  localparam int LAT   = 1;
  localparam int NSLOT = 6;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_start;
  logic        line_start;
  logic [23:0] time_bcd;
  logic [3:0]  lk_number;
  logic        lk_valid;
  logic [5:0]  lk_digit_index;
  logic [2:0]  slot_sel;
  logic        slot_valid;
  logic [5:0]  digit_index;
  logic        digit_valid;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int exp_a [8];
  int exp_b [8];
  int cyc;

  logic [5:0] rom_q [LAT];

  always #5 clk = ~clk;

  // Lookup ROM model: index = number*5, LAT register stages.
  always_ff @(posedge clk) begin
    rom_q[0] <= 6'(lk_number) * 6'd5;
    for (int i = 1; i < LAT; i++) rom_q[i] <= rom_q[i-1];
  end
  assign lk_digit_index = rom_q[LAT-1];

  digit_fetch_sched #(
    .LK_LATENCY (LAT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .frame_start    (frame_start),
    .line_start     (line_start),
    .time_bcd       (time_bcd),
    .lk_number      (lk_number),
    .lk_valid       (lk_valid),
    .lk_digit_index (lk_digit_index),
    .slot_sel       (slot_sel),
    .slot_valid     (slot_valid),
    .digit_index    (digit_index),
    .digit_valid    (digit_valid),
    .busy           (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick;
      n++;
    end
    if (n >= 100) check_eq("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic read_slot(input int s, input int exp_idx, input int exp_v, input string tag);
    slot_sel   = 3'(s);
    slot_valid = 1'b1;
    tick;
    check_eq({tag, "_valid"}, 32'(digit_valid), 32'(exp_v));
    if (exp_v != 0) check_eq({tag, "_index"}, 32'(digit_index), 32'(exp_idx));
  endtask

  initial begin
`ifdef DIGIT_SCHED_COLON_EN
    exp_a = '{1, 2, 11, 3, 4, 11, 5, 6};
    exp_b = '{10, 9, 11, 0, 0, 11, 0, 0};
`else
    exp_a = '{1, 2, 3, 4, 5, 6, 0, 0};
    exp_b = '{10, 9, 0, 0, 0, 0, 0, 0};
`endif
    reset_n     = 1'b0;
    frame_start = 1'b0;
    line_start  = 1'b0;
    time_bcd    = '0;
    slot_sel    = '0;
    slot_valid  = 1'b0;
    #12;
    check_eq("rst_lk_valid", 32'(lk_valid), 32'd0);
    check_eq("rst_lk_number", 32'(lk_number), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_digit_valid", 32'(digit_valid), 32'd0);
    check_eq("rst_digit_index", 32'(digit_index), 32'd0);
    reset_n = 1'b1;
    tick;
    tick;

    // Basic fill from snapshot 12:34:56
    time_bcd    = 24'h123456;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    line_start  = 1'b1;
    tick;
    line_start  = 1'b0;
    for (int k = 0; k < NSLOT; k++) begin
      check_eq("fill_lk_valid", 32'(lk_valid), 32'd1);
      check_eq("fill_lk_number", 32'(lk_number), 32'(exp_a[k]));
      check_eq("fill_busy", 32'(busy), 32'd1);
      tick;
    end
    for (int d = 0; d < LAT; d++) begin
      check_eq("drain_busy", 32'(busy), 32'd1);
      check_eq("drain_lk_valid", 32'(lk_valid), 32'd0);
      tick;
    end
    check_eq("fill_done_busy", 32'(busy), 32'd0);

    for (int s = 0; s < NSLOT; s++) read_slot(s, exp_a[s] * 5, 1, "rd_a");
`ifndef DIGIT_SCHED_COLON_EN
    read_slot(6, 0, 0, "rd_slot6");
    check_eq("rd_slot6_hold", 32'(digit_index), 32'd30);
    read_slot(7, 0, 0, "rd_slot7");
`endif
    slot_sel   = 3'd3;
    slot_valid = 1'b0;
    tick;
    check_eq("rd_novalid", 32'(digit_valid), 32'd0);

    // Same-cycle frame_start + line_start with invalid BCD; reads during fetch
    time_bcd    = 24'hF90000;
    frame_start = 1'b1;
    line_start  = 1'b1;
    slot_sel    = 3'd3;
    slot_valid  = 1'b1;
    tick;
    frame_start = 1'b0;
    line_start  = 1'b0;
    for (int k = 0; k < NSLOT; k++) begin
      check_eq("blank_lk_number", 32'(lk_number), 32'(exp_b[k]));
      if (k == 0) begin
        check_eq("rd_during_fetch_valid", 32'(digit_valid), 32'd1);
        check_eq("rd_during_fetch_index", 32'(digit_index), 32'(exp_a[3] * 5));
      end
      tick;
    end
    wait_idle;
    read_slot(0, exp_b[0] * 5, 1, "rd_b0");
    read_slot(1, exp_b[1] * 5, 1, "rd_b1");
    read_slot(3, exp_b[3] * 5, 1, "rd_b3");

    // Abort by a second line_start at fetch cycle 3
    time_bcd    = 24'h123456;
    frame_start = 1'b1;
    line_start  = 1'b1;
    tick;
    frame_start = 1'b0;
    line_start  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_eq("abort_pre_lk_number", 32'(lk_number), 32'(exp_a[k]));
      if (k < 3) tick;
    end
    line_start = 1'b1;
    slot_sel   = 3'd0;
    slot_valid = 1'b1;
    tick;
    line_start = 1'b0;
    check_eq("abort_restart_lk_valid", 32'(lk_valid), 32'd1);
    check_eq("abort_restart_lk_number", 32'(lk_number), 32'(exp_a[0]));
    check_eq("abort_busy_c0", 32'(busy), 32'd1);
    tick;
    check_eq("abort_cleared_slot0", 32'(digit_valid), 32'd0);
    check_eq("abort_busy_c1", 32'(busy), 32'd1);
    slot_sel = 3'd5;
    tick;
    check_eq("abort_cleared_slot5", 32'(digit_valid), 32'd0);
    cyc = 2;
    while (busy && cyc < 100) begin
      cyc++;
      tick;
    end
    check_eq("abort_busy_len", 32'(cyc), 32'(NSLOT + LAT));
    read_slot(0, exp_a[0] * 5, 1, "abort_refill_rd0");
    read_slot(5, exp_a[5] * 5, 1, "abort_refill_rd5");

    // Asynchronous reset in the middle of a fetch
    line_start = 1'b1;
    slot_sel   = 3'd0;
    slot_valid = 1'b1;
    tick;
    line_start = 1'b0;
    tick;
    check_eq("pre_rst_digit_valid", 32'(digit_valid), 32'd1);
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    check_eq("pre_rst_lk_valid", 32'(lk_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_lk_valid", 32'(lk_valid), 32'd0);
    check_eq("async_rst_busy", 32'(busy), 32'd0);
    check_eq("async_rst_digit_valid", 32'(digit_valid), 32'd0);
    check_eq("async_rst_lk_number", 32'(lk_number), 32'd0);
    #1;
    reset_n = 1'b1;
    tick;
    check_eq("post_rst_rd_valid", 32'(digit_valid), 32'd0);
    tick;
    check_eq("post_rst_rd_valid2", 32'(digit_valid), 32'd0);
    time_bcd    = 24'h123456;
    frame_start = 1'b1;
    line_start  = 1'b1;
    tick;
    frame_start = 1'b0;
    line_start  = 1'b0;
    wait_idle;
    read_slot(4, exp_a[4] * 5, 1, "post_rst_refill_rd4");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
